io_out_capture: RTL
===================

// Module: io_out_capture
// PURPOSE
//   Host-side reader for the processor's 8-bit output port. Captures each byte
//   the processor writes on out/outen into a small FIFO. Presents the bytes to
//   a host or testbench consumer over a valid/ready stream.
//   Sits beside the processor top: cpu_out <- processor out, cpu_outen <- outen.
// PARAMETERS
//   DATA_W   8   width of captured byte; must match processor out width
//   DEPTH    4   FIFO entries; power of two, >= 2
//   EDGE_CAP 1   1: capture on rising edge of cpu_outen; 0: capture every cycle outen=1
// PORTS
//   clk        in   1                  single clock; all logic on posedge clk
//   reset      in   1                  synchronous, active-high; clears all state
//   cpu_out    in   DATA_W             processor output port value
//   cpu_outen  in   1                  processor output-enable strobe
//   m_data     out  DATA_W             FIFO head byte
//   m_valid    out  1                  head byte valid
//   m_ready    in   1                  consumer accepts head this cycle
//   count      out  $clog2(DEPTH)+1    occupancy, 0..DEPTH
//   ovf        out  1                  sticky: a capture was dropped while full
// BEHAVIOUR
//   - Reset (sync, active-high): rd/wr pointers = 0, count = 0, m_valid = 0,
//     m_data = 0, ovf = 0, outen_q = 0. Reset mid-stream discards all entries.
//   - Capture event cap:
//     - EDGE_CAP=1: cpu_outen & ~outen_q. outen_q is cpu_outen registered.
//       A multi-cycle outen assertion yields exactly one capture of the first-cycle cpu_out.
//     - EDGE_CAP=0: cap = cpu_outen.
//   - push = cap & (~full | pop); pop = m_valid & m_ready.
//   - Latency: a byte pushed in cycle N is visible on m_data/m_valid in cycle N+1.
//   - m_data is the registered head. It is held stable while m_valid=1 and m_ready=0.
//   - Full + pop + cap in the same cycle: both happen; count unchanged; no overflow.
//   - Full + cap, no pop: byte dropped and ovf <= 1. ovf clears only on reset.
//   - Empty + cap + m_ready=1: no same-cycle bypass. Byte appears next cycle.
//   - Pointers wrap modulo DEPTH. count = wr-rd tracked separately.
//     full = (count==DEPTH); empty = (count==0).
//   - m_valid = ~empty. m_data = 0 when empty.
// CONFIGURATION
//   IO_CAPTURE_DROPCNT_EN:
//     - Defined: adds output drop_cnt [7:0]. It increments on every dropped
//       capture and saturates at 8'hFF. Reset to 0.
//     - Undefined: port absent; only sticky ovf reports loss.
// STRUCTURE
//   - Shared package io_pkg: localparam IO_DATA_W = 8.
//   - io_pkg also holds a helper function for the occupancy width ($clog2(DEPTH)+1).
//   - Sub-module io_sync_fifo: generic DEPTH x DATA_W synchronous FIFO with
//     push/pop/full/empty/count.
//   - Top holds the edge detector, overflow logic and optional drop counter.
// TESTING
//   1 Reset with DEPTH=4: count=0, m_valid=0, ovf=0.
//     Pulse outen 1 cycle with out=8'h5A, m_ready=0 -> next cycle m_valid=1,
//     m_data=8'h5A, count=1.
//   2 EDGE_CAP=1: hold outen high 3 cycles with out=8'h11,8'h22,8'h33 ->
//     exactly one entry (8'h11), count=1.
//   3 Five single-cycle captures 8'h01..8'h05, m_ready=0 -> count=4, ovf=1,
//     and drop_cnt=1 with IO_CAPTURE_DROPCNT_EN.
//     Then drain with m_ready=1 -> 8'h01..8'h04 in order.
//   4 Fill to 4 entries. Capture 8'hAA while m_ready=1 -> count stays 4,
//     ovf=0, 8'hAA read last.
//   5 Fill 3 entries, assert reset 1 cycle mid-stream -> count=0, m_valid=0,
//     ovf=0 on next cycle. Old data never reappears.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the processor I/O capture blocks: the default byte
// width and a helper that sizes FIFO occupancy counters.
package io_pkg;

  localparam int IO_DATA_W = 8;

  // The counter must hold every value from 0 up to DEPTH, so it needs one more bit than a pointer.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Generic DEPTH x DATA_W synchronous FIFO with a registered head output.
// dout holds zero whenever the FIFO is empty.
module io_sync_fifo
  import io_pkg::*;
#(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W-1:0]            dout,
  output logic                         full,
  output logic                         empty,
  output logic [occ_width(DEPTH)-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = occ_width(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Look ahead to the next head entry; it may be the byte being written this cycle.
    if (count_d == '0)
      head_d = '0;
    else if (do_push && (wr_ptr_q == rd_ptr_d))
      head_d = din;
    else
      head_d = mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign dout  = head_q;
  assign count = count_q;

endmodule

// File: rtl/io_out_capture.sv
// Captures bytes written on the processor output port into a FIFO and streams
// them out over valid/ready. Optional drop counter: IO_CAPTURE_DROPCNT_EN.
module io_out_capture
  import io_pkg::*;
#(
  parameter int DATA_W   = IO_DATA_W,
  parameter int DEPTH    = 4,
  parameter int EDGE_CAP = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            cpu_out,
  input  logic                         cpu_outen,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [occ_width(DEPTH)-1:0]  count,
  output logic                         ovf
`ifdef IO_CAPTURE_DROPCNT_EN
  ,
  output logic [7:0]                   drop_cnt
`endif
);

  logic outen_q, outen_d;
  logic ovf_q, ovf_d;
  logic cap, push, pop, drop;
  logic full, empty;

  generate
    if (EDGE_CAP != 0) begin : g_edge
      assign cap = cpu_outen & ~outen_q;
    end else begin : g_level
      assign cap = cpu_outen;
    end
  endgenerate

  assign pop  = m_valid & m_ready;
  assign push = cap & (~full | pop);
  // A capture that arrives while full with nothing leaving is lost.
  assign drop = cap & full & ~pop;

  always_comb begin
    outen_d = cpu_outen;
    ovf_d   = ovf_q | drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outen_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      outen_q <= outen_d;
      ovf_q   <= ovf_d;
    end
  end

  io_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (cpu_out),
    .dout  (m_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign m_valid = ~empty;
  assign ovf     = ovf_q;

`ifdef IO_CAPTURE_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= 8'd0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
